ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand and HI/LO width; must be even and >= 8.
REQ-002 Parameter MUL_BITS, default 1, multiplier bits retired per cycle; must divide XLEN.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  request to issue op this cycle.
REQ-006 op  input  3  muldiv_op_e: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 rs_val  input  XLEN  forwarded Rs operand; dividend or multiplicand; MTHI/MTLO source.
REQ-008 rt_val  input  XLEN  forwarded Rt operand; divisor or multiplier.
REQ-009 stall  input  1  EX stage held by hazard controller; start ignored while 1.
REQ-010 flush  input  1  CP0 flush; cancels any operation in flight.
REQ-011 busy  output  1  operation in flight; drives ALUStall.
REQ-012 done  output  1  one-cycle pulse on the cycle hi/lo first show a MULT/DIV result.
REQ-013 hi, lo  output  XLEN each  architectural HI/LO registers; MFHI/MFLO read these directly.

Function
REQ-014 Accepted issue: start=1, stall=0, flush=0, state IDLE; in every other state start is ignored.
REQ-015 FSM states: IDLE, MUL, DIV, FIX.
- IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU.
- MUL->FIX after XLEN/MUL_BITS iterations; DIV->FIX after XLEN iterations.
- FIX->IDLE after one cycle.
REQ-016 MTHI/MTLO: on an accepted issue, hi or lo = rs_val at the next edge; state stays IDLE; busy stays 0; done stays 0.
REQ-017 op NONE with start=1 has no effect.
REQ-018 Operand capture on issue:
- Signed ops latch absolute values plus the result sign bits.
- Quotient sign = rs[XLEN-1]^rt[XLEN-1]; remainder sign = rs[XLEN-1]; product sign = rs[XLEN-1]^rt[XLEN-1].
- Unsigned ops latch operands unchanged with sign bits 0.
REQ-019 MUL datapath: shift-add over a 2*XLEN accumulator, MUL_BITS multiplier bits per cycle.
REQ-020 DIV datapath: restoring division, one quotient bit per cycle.
REQ-021 FIX: negate product, quotient and remainder where their sign bits are set, then write hi/lo.
- MULT/MULTU: hi = upper XLEN bits, lo = lower XLEN bits.
- DIV/DIVU: lo = quotient, hi = remainder.
REQ-022 FIX always executes, including for unsigned ops, so latency is fixed: MUL = XLEN/MUL_BITS+1 cycles, DIV = XLEN+1 cycles.
REQ-023 busy = 1 from the cycle after issue through the FIX cycle inclusive.
REQ-024 hi/lo update and done pulse at the edge ending FIX, so done coincides with busy falling.
REQ-025 Divide by zero (rt_val=0): lo = all-ones, hi = rs_val; sign fixup suppressed; latency unchanged.
REQ-026 Signed overflow (rs = most-negative value, rt = -1): lo = most-negative value, hi = 0; this falls out of the abs/negate path.
REQ-027 flush=1 in any state:
- state = IDLE at the next edge; busy = 0, done = 0.
- hi/lo unchanged, because results commit only in FIX.
REQ-028 flush and start in the same cycle: flush wins; no MTHI/MTLO write, no issue.
REQ-029 stall=1 does not pause an operation already in flight.

Reset
REQ-030 rst_n=0 at an edge, including mid-operation:
- state = IDLE, busy = 0, done = 0, hi = 0, lo = 0.
- Iteration counter, accumulators and sign bits = 0.
REQ-031 Reset has priority over flush and start.

Structure
REQ-032 Package ex_muldiv_pkg holds muldiv_op_e, the FSM state enum, and the op-decode helper constants.
REQ-033 One sub-module, ex_div_iter: combinational restoring-divide step taking remainder, quotient and divisor, returning next remainder and quotient.
REQ-034 Counter width = $clog2(XLEN)+1; no latches; all outputs registered.

Verification (XLEN=32, MUL_BITS=1)
REQ-035 MULT rs=0xFFFFFFFD, rt=7 -> busy 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once.
REQ-036 DIVU 100/7 -> lo=14, hi=2 after 33 cycles; DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIV 5/0 -> lo=0xFFFFFFFF, hi=5.
REQ-038 Start DIV with hi=0x11, lo=0x22; flush on busy cycle 10 -> busy=0 next cycle, hi=0x11, lo=0x22, no done.
REQ-039 MTHI rs=0xABCD while busy -> ignored, hi unchanged; same MTHI in IDLE with stall=1 -> ignored; with stall=0 -> hi=0xABCD next cycle.
REQ-040 rst_n=0 mid-MULT -> next cycle busy=0, hi=lo=0; a new MULTU 0xFFFFFFFF*2 then gives hi=1, lo=0xFFFFFFFE.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit: op codes, FSM states
// and op-decode helpers.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } muldiv_state_e;

  function automatic logic op_is_mul(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic            start;
  muldiv_op_e      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            stall;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, stall, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, stall, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/ex_muldiv_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits and record the quotient bit.
module ex_div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    fits    = ~diff[XLEN];
    rem_o   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply, restoring
// divide, with a fixed sign-fixup cycle before the result commits.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave bus
);

  localparam int unsigned     CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_BITS - 1);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);

  muldiv_state_e     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              is_div_q, is_div_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              rs_neg, rt_neg, div_zero;
  logic [XLEN-1:0]   rs_abs, rt_abs;
  logic [2*XLEN:0]   mul_tmp;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   rem_nxt, quo_nxt;

  ex_div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_i (acc_q[2*XLEN-1:XLEN]),
    .quo_i (acc_q[XLEN-1:0]),
    .div_i (opnd_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  always_comb begin
    accept   = bus.start && !bus.stall && !bus.flush && (state_q == S_IDLE);
    rs_neg   = op_is_signed(bus.op) && bus.rs_val[XLEN-1];
    rt_neg   = op_is_signed(bus.op) && bus.rt_val[XLEN-1];
    rs_abs   = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_abs   = rt_neg ? -bus.rt_val : bus.rt_val;
    div_zero = (bus.rt_val == '0);
  end

  // Upper half accumulates the multiplicand; the multiplier drains from the
  // bottom as the accumulator shifts right, carry landing in the top bit.
  always_comb begin
    mul_tmp = {1'b0, acc_q};
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (mul_tmp[0]) begin
        mul_tmp[2*XLEN:XLEN] = {1'b0, mul_tmp[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
      end
      mul_tmp = mul_tmp >> 1;
    end
    prod = neg_lo_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_is_mul(bus.op)) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = {{XLEN{1'b0}}, rt_abs};
            opnd_d   = rs_abs;
            neg_lo_d = rs_neg ^ rt_neg;
            neg_hi_d = rs_neg ^ rt_neg;
            is_div_d = 1'b0;
          end else if (op_is_div(bus.op)) begin
            state_d  = S_DIV;
            cnt_d    = '0;
            opnd_d   = rt_abs;
            is_div_d = 1'b1;
            // Divide by zero runs unsigned on the raw dividend: the restoring
            // loop then yields all-ones quotient and remainder = rs_val.
            if (div_zero) begin
              acc_d    = {{XLEN{1'b0}}, bus.rs_val};
              neg_lo_d = 1'b0;
              neg_hi_d = 1'b0;
            end else begin
              acc_d    = {{XLEN{1'b0}}, rs_abs};
              neg_lo_d = rs_neg ^ rt_neg;
              neg_hi_d = rs_neg;
            end
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.rs_val;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.rs_val;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_tmp[2*XLEN-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MUL_LAST) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {rem_nxt, quo_nxt};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          hi_d = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vectors plus randomized ops
// checked against an arithmetic HI/LO reference model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned LAT  = 33;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ex_muldiv_if #(.XLEN(XLEN)) bus ();

  ex_muldiv #(.XLEN(XLEN), .MUL_BITS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: HI/LO after an op, from plain arithmetic on the operands.
  function automatic void model(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    case (o)
      OP_MULT:  begin ps = $signed(a) * $signed(b); {h, l} = ps; end
      OP_MULTU: begin pu = {32'd0, a} * {32'd0, b}; {h, l} = pu; end
      OP_DIV: begin
        if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = 32'd0; end
        else begin l = $signed(a) / $signed(b); h = $signed(a) % $signed(b); end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
        else begin l = a / b; h = a % b; end
      end
      OP_MTHI: h = a;
      OP_MTLO: l = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and follow it until busy drops; bounded so it cannot hang.
  task automatic exec(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b,
                      input logic stall_during, output int bc, output int dc);
    bc = 0;
    dc = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.stall = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NONE; bus.stall = stall_during;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) dc++;
      if (!bus.busy) break;
      bc++;
      @(negedge clk);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    if (bus.done) dc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    int bc, dc;
    exec(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, bc, dc);
    n_tests++;
    if (bc !== LAT) begin n_fail++; $display("FAIL mult_latency: got %0d required %0d", bc, LAT); end
    n_tests++;
    if (dc !== 1) begin n_fail++; $display("FAIL mult_done: got %0d pulses required 1", dc); end
    n_tests++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
      n_fail++;
      $display("FAIL mult_result: hi=%h lo=%h required ffffffff ffffffeb", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    int bc, dc;
    exec(OP_DIVU, 32'd100, 32'd7, 1'b0, bc, dc);
    n_tests++;
    if (bc !== LAT || dc !== 1) begin
      n_fail++; $display("FAIL divu_timing: busy=%0d done=%0d required %0d 1", bc, dc, LAT);
    end
    n_tests++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      n_fail++; $display("FAIL divu_result: hi=%h lo=%h required 2 e", bus.hi, bus.lo);
    end
    exec(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, bc, dc);
    n_tests++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div_neg: hi=%h lo=%h required ffffffff fffffffd", bus.hi, bus.lo);
    end
    exec(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc, dc);
    n_tests++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
      n_fail++; $display("FAIL div_overflow: hi=%h lo=%h required 0 80000000", bus.hi, bus.lo);
    end
    exec(OP_DIV, 32'd5, 32'd0, 1'b0, bc, dc);
    n_tests++;
    if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd5 || bc !== LAT) begin
      n_fail++;
      $display("FAIL div_zero: hi=%h lo=%h busy=%0d required 5 ffffffff %0d", bus.hi, bus.lo, bc, LAT);
    end
  endtask

  task automatic test_flush();
    int bc, dc;
    exec(OP_MTHI, 32'h11, 32'd0, 1'b0, bc, dc);
    exec(OP_MTLO, 32'h22, 32'd0, 1'b0, bc, dc);
    n_tests++;
    if (bus.hi !== 32'h11 || bus.lo !== 32'h22 || bc !== 0 || dc !== 0) begin
      n_fail++;
      $display("FAIL mt_setup: hi=%h lo=%h busy=%0d done=%0d required 11 22 0 0", bus.hi, bus.lo, bc, dc);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.rs_val = 32'd1000; bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NONE;
    repeat (9) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b required 1", bus.busy); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      n_fail++;
      $display("FAIL flush_cancel: busy=%b done=%b hi=%h lo=%h required 0 0 11 22",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    dc = 0;
    repeat (40) begin @(negedge clk); if (bus.done || bus.busy) dc++; end
    n_tests++;
    if (dc !== 0 || bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      n_fail++; $display("FAIL flush_quiet: activity=%0d hi=%h lo=%h required 0 11 22", dc, bus.hi, bus.lo);
    end
    bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_val = 32'h77; bus.flush = 1'b1;
    @(negedge clk);
    bus.op = OP_DIVU;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NONE; bus.flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.hi !== 32'h11 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_start: hi=%h busy=%b required 11 0", bus.hi, bus.busy);
    end
  endtask

  task automatic test_mthi();
    int dc;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.rs_val = 32'hFFFF_FFFD; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NONE;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_val = 32'hABCD;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NONE;
    dc = 0;
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    if (bus.done) dc++;
    n_tests++;
    if (bus.busy !== 1'b0 || dc !== 1 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
      n_fail++;
      $display("FAIL mthi_busy: busy=%b done=%0d hi=%h lo=%h required 0 1 ffffffff ffffffeb",
               bus.busy, dc, bus.hi, bus.lo);
    end
    bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_val = 32'hABCD; bus.stall = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stall = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.hi !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mthi_stall: hi=%h required ffffffff", bus.hi);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NONE;
    n_tests++;
    if (bus.hi !== 32'hABCD || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL mthi_idle: hi=%h busy=%b done=%b required abcd 0 0", bus.hi, bus.busy, bus.done);
    end
  endtask

  task automatic test_start_ignored();
    int bc;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.op = OP_MTLO; bus.rs_val = 32'h55;
    bc = 0;
    for (int i = 0; i < 100 && bus.busy; i++) begin bc++; @(negedge clk); end
    bus.start = 1'b0; bus.op = OP_NONE;
    n_tests++;
    if (bc !== LAT || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      n_fail++;
      $display("FAIL start_ignored: busy=%0d hi=%h lo=%h required %0d 2 e", bc, bus.hi, bus.lo, LAT);
    end
  endtask

  task automatic test_reset_mid();
    int bc, dc;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.rs_val = 32'h1234; bus.rt_val = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NONE;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.flush = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    exec(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, bc, dc);
    n_tests++;
    if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE || bc !== LAT || dc !== 1) begin
      n_fail++;
      $display("FAIL multu_after_reset: hi=%h lo=%h busy=%0d done=%0d required 1 fffffffe %0d 1",
               bus.hi, bus.lo, bc, dc, LAT);
    end
  endtask

  task automatic test_random();
    int          bc, dc, exp_bc, exp_dc;
    logic [31:0] a, b, eh, el;
    muldiv_op_e  o;
    eh = $urandom;
    el = $urandom;
    exec(OP_MTHI, eh, 32'd0, 1'b0, bc, dc);
    exec(OP_MTLO, el, 32'd0, 1'b0, bc, dc);
    for (int n = 0; n < 60; n++) begin
      o = muldiv_op_e'($urandom_range(0, 6));
      a = pick();
      b = pick();
      exec(o, a, b, 1'($urandom_range(0, 1)), bc, dc);
      model(o, a, b, eh, el);
      exp_bc = (op_is_mul(o) || op_is_div(o)) ? LAT : 0;
      exp_dc = (exp_bc != 0) ? 1 : 0;
      n_tests++;
      if (bus.hi !== eh || bus.lo !== el || bc !== exp_bc || dc !== exp_dc) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h busy=%0d done=%0d required %h %h %0d %0d",
                 n, o, a, b, bus.hi, bus.lo, bc, dc, eh, el, exp_bc, exp_dc);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = OP_NONE; bus.rs_val = '0; bus.rt_val = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_mthi();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
